// File: rtl/decodificador_pkg.sv
// Shared constants and helpers for the dual one-hot decoder slice.
package decodificador_pkg;

    localparam int SEL_W_DEFAULT = 2;

    // Output width is always the full code space of the select input.
    function automatic int outWidth(input int selW);
        return 1 << selW;
    endfunction

endpackage : decodificador_pkg

// File: rtl/decodificador_canal.sv
// One registered, enable-gated one-hot decoder channel.
module decodificador_canal
    import decodificador_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT,
    localparam int OUT_W = outWidth(SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [SEL_W-1:0] code,
    output logic [OUT_W-1:0] onehot
);

    logic [OUT_W-1:0] onehot_d;
    logic [OUT_W-1:0] onehot_q;

    // Every code maps to a bit, so no range guard is needed.
    always_comb begin
        onehot_d = '0;
        if (enable) begin
            onehot_d[code] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign onehot = onehot_q;

endmodule : decodificador_canal

// File: rtl/decodificador_dual.sv
// Two independent registered one-hot decoders sharing clock and reset.
module decodificador_dual
    import decodificador_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT,
    localparam int OUT_W = outWidth(SEL_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    input  logic             enab,
    input  logic [SEL_W-1:0] bit_sel,
    output logic [OUT_W-1:0] sort
);

    decodificador_canal #(
        .SEL_W(SEL_W)
    ) canalA (
        .clk   (clk),
        .rst   (rst),
        .enable(en),
        .code  (sel),
        .onehot(out)
    );

    decodificador_canal #(
        .SEL_W(SEL_W)
    ) canalB (
        .clk   (clk),
        .rst   (rst),
        .enable(enab),
        .code  (bit_sel),
        .onehot(sort)
    );

endmodule : decodificador_dual

// File: tb/tb_decodificador_dual.sv
// Scoreboard bench for decodificador_dual: stimulus pushes expectations, a monitor pops and compares.
module tb_decodificador_dual;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic [3:0] out;
    logic       enab;
    logic [1:0] bitSel;
    logic [3:0] sort;

    int assertCount = 0;
    int failCount   = 0;

    logic [3:0] expOutQ[$];
    logic [3:0] expSortQ[$];
    string      tagQ[$];

    decodificador_dual dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sel    (sel),
        .out    (out),
        .enab   (enab),
        .bit_sel(bitSel),
        .sort   (sort)
    );

    always #5 clk = ~clk;

    // Reference: selected code becomes the power of two 2**code, or nothing when disabled or in reset.
    function automatic logic [3:0] refDecode(input bit resetV, input bit enableV, input int code);
        int value;
        value = (resetV || !enableV) ? 0 : (2 ** code);
        return value[3:0];
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit rstV, input bit enV, input int selV,
                                 input bit enabV, input int bitSelV);
        @(negedge clk);
        rst    = rstV;
        en     = enV;
        sel    = selV[1:0];
        enab   = enabV;
        bitSel = bitSelV[1:0];
        expOutQ.push_back(refDecode(rstV, enV, selV));
        expSortQ.push_back(refDecode(rstV, enabV, bitSelV));
        tagQ.push_back(tag);
    endtask

    // Monitor: one registered result per edge, checked 1 time unit after the edge.
    initial begin
        string tag;
        forever begin
            @(posedge clk);
            #1;
            if (expOutQ.size() > 0) begin
                tag = tagQ.pop_front();
                checkOutput({tag, "_out"}, out, expOutQ.pop_front());
                checkOutput({tag, "_sort"}, sort, expSortQ.pop_front());
                checkOutput({tag, "_onehot0_out"}, {3'b000, $onehot0(out)}, 4'b0001);
                checkOutput({tag, "_onehot0_sort"}, {3'b000, $onehot0(sort)}, 4'b0001);
            end
        end
    end

    initial begin
        #200000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        rst = 1'b1; en = 1'b0; sel = '0; enab = 1'b0; bitSel = '0;

        applyStimulus("reset0", 1, 1, 3, 1, 3);
        applyStimulus("reset1", 1, 1, 3, 1, 3);
        applyStimulus("release", 0, 1, 3, 1, 3);

        for (int i = 0; i < 4; i++) applyStimulus("sweep", 0, 1, i, 1, 3 - i);
        for (int i = 0; i < 4; i++) applyStimulus("disableA", 0, 0, i, 1, i);
        for (int i = 0; i < 4; i++) applyStimulus("disableB", 0, 1, i, 0, i);

        applyStimulus("indep0", 0, 1, 1, 0, 2);
        applyStimulus("indep1", 0, 0, 1, 1, 2);

        applyStimulus("latency0", 0, 1, 2, 1, 0);
        applyStimulus("latency1", 0, 1, 2, 1, 0);
        applyStimulus("latencyN", 0, 1, 3, 1, 0);
        applyStimulus("latencyN1", 0, 1, 3, 1, 0);
        applyStimulus("latencyN2", 0, 1, 3, 1, 0);
        applyStimulus("midReset", 1, 1, 3, 1, 0);
        applyStimulus("afterReset", 0, 1, 3, 1, 0);
        applyStimulus("holdConst", 0, 1, 3, 1, 0);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus("random", ($urandom_range(31) == 0), $urandom_range(1), $urandom_range(3),
                          $urandom_range(1), $urandom_range(3));
        end

        repeat (3) @(negedge clk);
        assertCount++;
        if (expOutQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drained: got %0d pending, expected 0", expOutQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_decodificador_dual
